alu_seq_master: RTL

- Initiator for the 16-bit combinational ALU (op: 00 add, 01 sub, 10 and, 11 or; result, carry and overflow outputs).
- Accepts register-level commands over a valid/ready interface and buffers them in a small FIFO.
- Reads operands from an internal register file, drives the ALU, captures the result, writes it back, updates flags and returns a response over valid/ready.
- Sits between the control path and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_master_if.sv | 61 ++++++
 rtl/alu_seq_fifo.sv | 68 ++++++
 rtl/alu_seq_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencing master:
//   - datapath width / register-file size used by the command struct
//   - ALU opcode constants
//   - sequencer state enum
//   - packed command struct carried through the command FIFO
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_NREGS = 4;
    localparam int REG_IDX_W = $clog2(ALU_NREGS);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 load;
        logic [1:0]           op;
        logic [REG_IDX_W-1:0] dst;
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
        logic [ALU_WIDTH-1:0] imm;
    } cmd_t;

endpackage

// File: rtl/alu_seq_master_if.sv
// ---------------------------------------------------------------------------
// alu_seq_master_if
// Bundles the command channel, the ALU drive/return signals, the response
// channel and the flag outputs of alu_seq_master.
//   master : view of alu_seq_master
//   slave  : view of the environment (control path + ALU)
// Parameters: WIDTH (datapath), NREGS (register file entries).
// ---------------------------------------------------------------------------
interface alu_seq_master_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
);
    localparam int IW = $clog2(NREGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [1:0]       cmd_op;
    logic [IW-1:0]    cmd_dst;
    logic [IW-1:0]    cmd_src_a;
    logic [IW-1:0]    cmd_src_b;
    logic [WIDTH-1:0] cmd_imm;

    logic [WIDTH-1:0] alu_i0;
    logic [WIDTH-1:0] alu_i1;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_o;
    logic             alu_carry;
    logic             alu_overflow;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [IW-1:0]    res_dst;
    logic             res_carry;
    logic             res_overflow;

    logic             flag_c;
    logic             flag_v;

    modport master (
        input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output cmd_ready,
        output alu_i0, alu_i1, alu_op,
        input  alu_o, alu_carry, alu_overflow,
        output res_valid, res_data, res_dst, res_carry, res_overflow,
        input  res_ready,
        output flag_c, flag_v
    );

    modport slave (
        output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  cmd_ready,
        input  alu_i0, alu_i1, alu_op,
        output alu_o, alu_carry, alu_overflow,
        input  res_valid, res_data, res_dst, res_carry, res_overflow,
        output res_ready,
        input  flag_c, flag_v
    );

endinterface

// File: rtl/alu_seq_fifo.sv
// ---------------------------------------------------------------------------
// alu_seq_fifo
// Synchronous command FIFO over cmd_t with asynchronous active-high reset.
// Ports:
//   clk, rst        clock / async reset
//   push, wr_data   write side (ignored while full)
//   pop, rd_data    read side, rd_data shows the head entry (ignored while empty)
//   full, empty     occupancy flags decoded from the registered count
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
// ---------------------------------------------------------------------------
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // simultaneous push and pop leaves the count unchanged
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq_master.sv
// ---------------------------------------------------------------------------
// alu_seq_master
// Sequencer that takes register-level commands, reads operands from an
// internal register file, drives an external combinational 16-bit ALU,
// writes the result back, updates carry/overflow flags and returns a
// response per command, in command order.
//
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   bus        alu_seq_master_if.master
//                cmd_*   command channel (valid/ready), buffered in a FIFO
//                alu_*   registered operands/opcode out, result/carry/ovf in
//                res_*   response channel (valid/ready), held while stalled
//                flag_c, flag_v  carry/overflow of the last ALU-op command
//   ALU_SEQ_STATUS_EN (optional build macro) adds:
//     stat_clr   clear sticky_v and done_cnt
//     sticky_v   set by any ALU-op response carrying overflow
//     done_cnt   count of accepted responses, wraps at 16 bits
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; pops it and loads ALU operands
// S_ISSUE | ALU settling; result written back and response raised
// S_RESP  | response held until res_ready
// ---------------------------------------------------------------------------
module alu_seq_master
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int NREGS      = ALU_NREGS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_master_if.master bus
`ifdef ALU_SEQ_STATUS_EN
    ,
    input  logic             stat_clr,
    output logic             sticky_v,
    output logic [15:0]      done_cnt
`endif
);
    localparam int IW = $clog2(NREGS);

    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic             cmd_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             cmd_pending;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];

    logic             cur_load;
    logic [IW-1:0]    cur_dst;
    logic [WIDTH-1:0] cur_imm;

    logic [WIDTH-1:0] alu_i0_q;
    logic [WIDTH-1:0] alu_i1_q;
    logic [1:0]       alu_op_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [IW-1:0]    res_dst_q;
    logic             res_carry_q;
    logic             res_overflow_q;
    logic             flag_c_q;
    logic             flag_v_q;

    always_comb begin
        cmd_in       = '0;
        cmd_in.load  = bus.cmd_load;
        cmd_in.op    = bus.cmd_op;
        cmd_in.dst   = bus.cmd_dst;
        cmd_in.src_a = bus.cmd_src_a;
        cmd_in.src_b = bus.cmd_src_b;
        cmd_in.imm   = bus.cmd_imm;
    end

    assign cmd_push      = bus.cmd_valid && !fifo_full;
    assign bus.cmd_ready = !fifo_full;

    // cmd_pending is a registered copy of !empty: a fresh command becomes
    // visible to the FSM one cycle after it is written, which gives the
    // handshake-to-response latency of three edges. It can also stay high
    // for one cycle after the last entry is popped; that is harmless since
    // the FSM spends ISSUE and RESP away from IDLE after every pop.
    assign fifo_pop = (state == S_IDLE) && cmd_pending;

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_push),
        .wr_data (cmd_in),
        .pop     (fifo_pop),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cmd_pending    <= 1'b0;
            cur_load       <= 1'b0;
            cur_dst        <= '0;
            cur_imm        <= '0;
            alu_i0_q       <= '0;
            alu_i1_q       <= '0;
            alu_op_q       <= OP_ADD;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_dst_q      <= '0;
            res_carry_q    <= 1'b0;
            res_overflow_q <= 1'b0;
            flag_c_q       <= 1'b0;
            flag_v_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            cmd_pending <= !fifo_empty;
            case (state)
                S_IDLE: begin
                    if (cmd_pending) begin
                        alu_i0_q <= regs[cmd_head.src_a];
                        alu_i1_q <= regs[cmd_head.src_b];
                        alu_op_q <= cmd_head.op;
                        cur_load <= cmd_head.load;
                        cur_dst  <= cmd_head.dst;
                        cur_imm  <= cmd_head.imm;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cur_load) begin
                        regs[cur_dst]  <= cur_imm;
                        res_data_q     <= cur_imm;
                        res_carry_q    <= 1'b0;
                        res_overflow_q <= 1'b0;
                    end else begin
                        regs[cur_dst]  <= bus.alu_o;
                        res_data_q     <= bus.alu_o;
                        res_carry_q    <= bus.alu_carry;
                        res_overflow_q <= bus.alu_overflow;
                        flag_c_q       <= bus.alu_carry;
                        flag_v_q       <= bus.alu_overflow;
                    end
                    res_dst_q   <= cur_dst;
                    res_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_i0       = alu_i0_q;
    assign bus.alu_i1       = alu_i1_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_dst      = res_dst_q;
    assign bus.res_carry    = res_carry_q;
    assign bus.res_overflow = res_overflow_q;
    assign bus.flag_c       = flag_c_q;
    assign bus.flag_v       = flag_v_q;

`ifdef ALU_SEQ_STATUS_EN
    logic sticky_set;
    logic cnt_inc;

    assign sticky_set = (state == S_ISSUE) && !cur_load && bus.alu_overflow;
    assign cnt_inc    = res_valid_q && bus.res_ready;

    // a set or increment coinciding with stat_clr takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_v <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (sticky_set) begin
                sticky_v <= 1'b1;
            end else if (stat_clr) begin
                sticky_v <= 1'b0;
            end
            if (stat_clr) begin
                done_cnt <= cnt_inc ? 16'd1 : 16'd0;
            end else if (cnt_inc) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
